// File: rtl/decode_secret.sv
// Receive-side check of the encode stage: walks the image in 4x4 blocks, rebuilds one 16-bit word per block.
// 33 cycles per block (read 17, classify 1, convert 14, emit 1); no backpressure, start ignored while busy.
module decode_secret #(
    parameter int IMG_DIM = 64,
    parameter int NDIGITS = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [23:0]   in_pix,
    output logic [5:0]    row,
    output logic [5:0]    col,
    output logic          word_valid,
    output logic [15:0]   word_data,
    output logic [7:0]    word_index,
    output logic [4095:0] decoded_string,
    output logic          decode_done,
    output logic          fmt_error
);
    localparam int NB   = IMG_DIM / 4;
    localparam int NBLK = NB * NB;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_CLASSIFY, S_CONVERT, S_EMIT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [3:0]      blk_row_q, blk_row_d, blk_col_q, blk_col_d;
    logic [7:0]      blk_idx_q, blk_idx_d;
    logic [7:0]      pix_q [16];
    logic [7:0]      pix_d [16];
    logic [1:0]      dig_q [NDIGITS];
    logic [1:0]      dig_d [NDIGITS];
    logic [22:0]     acc_q, acc_d, acc_next;
    logic [5:0]      row_q, row_d, col_q, col_d;
    logic            word_valid_q, word_valid_d;
    logic [15:0]     word_data_q, word_data_d;
    logic [7:0]      word_index_q, word_index_d;
    logic [4095:0]   str_q, str_d;
    logic            done_q, done_d, err_q, err_d;

    logic [1:0]      cls_dig [NDIGITS];
    logic            cls_err, found;
    logic [3:0]      ref2_idx, j, kn, nrow, ncol;
    logic [7:0]      ref2_val, base;
    logic            unused_pix;

    assign unused_pix = ^{in_pix[23:16], in_pix[7:0]};

    function automatic logic far(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? ((a - b) > 8'd1) : ((b - a) > 8'd1);
    endfunction

    // Reference 2 is the first pixel more than 1 away from pixel 0; uniform blocks fall back to position 1.
    always_comb begin
        found    = 1'b0;
        ref2_idx = 4'd1;
        ref2_val = pix_q[0];
        cls_err  = 1'b0;
        j        = 4'd0;
        base     = 8'd0;
        for (int k = 0; k < NDIGITS; k++) cls_dig[k] = 2'd0;
        for (int k = 1; k < 16; k++) begin
            if (!found && far(pix_q[k], pix_q[0])) begin
                found    = 1'b1;
                ref2_idx = 4'(k);
                ref2_val = pix_q[k];
            end
        end
        for (int k = 1; k < 16; k++) begin
            if (4'(k) != ref2_idx && j < 4'(NDIGITS)) begin
                base = far(pix_q[k], pix_q[0]) ? ref2_val : pix_q[0];
                if (pix_q[k] == base)
                    cls_dig[j] = 2'd0;
                else if ({1'b0, pix_q[k]} == {1'b0, base} + 9'd1)
                    cls_dig[j] = 2'd1;
                else if ({1'b0, pix_q[k]} + 9'd1 == {1'b0, base})
                    cls_dig[j] = 2'd2;
                else
                    cls_err = 1'b1;
                j = j + 4'd1;
            end
        end
    end

    assign acc_next = acc_q + {acc_q[21:0], 1'b0} + {21'd0, dig_q[cnt_q[3:0]]};
    assign kn       = cnt_q[3:0] + 4'd1;
    assign nrow     = (blk_col_q == 4'(NB - 1)) ? blk_row_q + 4'd1 : blk_row_q;
    assign ncol     = (blk_col_q == 4'(NB - 1)) ? 4'd0 : blk_col_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        blk_row_d    = blk_row_q;
        blk_col_d    = blk_col_q;
        blk_idx_d    = blk_idx_q;
        pix_d        = pix_q;
        dig_d        = dig_q;
        acc_d        = acc_q;
        row_d        = row_q;
        col_d        = col_q;
        word_valid_d = 1'b0;
        word_data_d  = word_data_q;
        word_index_d = word_index_q;
        str_d        = str_q;
        done_d       = done_q;
        err_d        = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_READ;
                    cnt_d     = 5'd0;
                    blk_row_d = 4'd0;
                    blk_col_d = 4'd0;
                    blk_idx_d = 8'd0;
                    row_d     = 6'd0;
                    col_d     = 6'd0;
                    str_d     = '0;
                    err_d     = 1'b0;
                    done_d    = 1'b0;
                end
            end
            S_READ: begin
                // Pixel for address cnt-1 arrives now; at cnt=16 the low nibble wraps to slot 15.
                if (cnt_q != 5'd0) pix_d[cnt_q[3:0] - 4'd1] = in_pix[15:8];
                if (cnt_q < 5'd15) begin
                    row_d = {blk_row_q, 2'b00} + {4'd0, kn[3:2]};
                    col_d = {blk_col_q, 2'b00} + {4'd0, kn[1:0]};
                end
                if (cnt_q == 5'd16) state_d = S_CLASSIFY;
                else                cnt_d   = cnt_q + 5'd1;
            end
            S_CLASSIFY: begin
                dig_d   = cls_dig;
                err_d   = err_q | cls_err;
                acc_d   = 23'd0;
                cnt_d   = 5'(NDIGITS - 1);
                state_d = S_CONVERT;
            end
            S_CONVERT: begin
                acc_d = acc_next;
                if (cnt_q == 5'd0) begin
                    state_d                          = S_EMIT;
                    word_valid_d                     = 1'b1;
                    word_data_d                      = acc_next[15:0];
                    word_index_d                     = blk_idx_q;
                    str_d[{blk_idx_q, 4'b0000} +: 16] = acc_next[15:0];
                    if (acc_next > 23'd65535) err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_EMIT: begin
                if (blk_idx_q == 8'(NBLK - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d   = S_READ;
                    cnt_d     = 5'd0;
                    blk_idx_d = blk_idx_q + 8'd1;
                    blk_row_d = nrow;
                    blk_col_d = ncol;
                    row_d     = {nrow, 2'b00};
                    col_d     = {ncol, 2'b00};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 5'd0;
            blk_row_q    <= 4'd0;
            blk_col_q    <= 4'd0;
            blk_idx_q    <= 8'd0;
            for (int k = 0; k < 16; k++) pix_q[k] <= 8'd0;
            for (int k = 0; k < NDIGITS; k++) dig_q[k] <= 2'd0;
            acc_q        <= 23'd0;
            row_q        <= 6'd0;
            col_q        <= 6'd0;
            word_valid_q <= 1'b0;
            word_data_q  <= 16'd0;
            word_index_q <= 8'd0;
            str_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            blk_row_q    <= blk_row_d;
            blk_col_q    <= blk_col_d;
            blk_idx_q    <= blk_idx_d;
            pix_q        <= pix_d;
            dig_q        <= dig_d;
            acc_q        <= acc_d;
            row_q        <= row_d;
            col_q        <= col_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
            word_index_q <= word_index_d;
            str_q        <= str_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign row            = row_q;
    assign col            = col_q;
    assign word_valid     = word_valid_q;
    assign word_data      = word_data_q;
    assign word_index     = word_index_q;
    assign decoded_string = str_q;
    assign decode_done    = done_q;
    assign fmt_error      = err_q;
endmodule

// File: tb/tb_decode_secret.sv
// Directed bench for decode_secret: single-block vectors, a full-image decode against an encoder model, and mid-run reset.
module tb_decode_secret;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [23:0]   in_pix = '0;
    logic [5:0]    row, col;
    logic          word_valid;
    logic [15:0]   word_data;
    logic [7:0]    word_index;
    logic [4095:0] decoded_string;
    logic          decode_done, fmt_error;

    logic [7:0]    img [0:63][0:63];
    logic [15:0]   exp_words [256];
    int            checks = 0;
    int            errors = 0;

    decode_secret dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_pix(in_pix),
        .row(row), .col(col), .word_valid(word_valid), .word_data(word_data),
        .word_index(word_index), .decoded_string(decoded_string),
        .decode_done(decode_done), .fmt_error(fmt_error)
    );

    always #5 clk = ~clk;

    // Synchronous image memory: pixel for the presented address appears one cycle later.
    always @(posedge clk) in_pix <= {8'hA5, img[row][col], 8'h5A};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_word(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (word_valid) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic blk0_fill(input logic [7:0] v);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) img[r][c] = v;
    endtask

    task automatic run_blk0(input string tag, input logic [15:0] exp_w, input logic exp_err);
        bit ok;
        pulse_start();
        wait_word(ok);
        check({tag, "_valid"}, 64'(ok), 64'd1);
        if (ok) begin
            check({tag, "_data"}, 64'(word_data), 64'(exp_w));
            check({tag, "_index"}, 64'(word_index), 64'd0);
            check({tag, "_err"}, 64'(fmt_error), 64'(exp_err));
        end
        do_reset();
    endtask

    // Encoder model: base-3 digits as +/-1 offsets; two-level blocks alternate digits between references.
    task automatic encode_block(input int n, input logic [15:0] w, input bit two);
        int         br = n / 16;
        int         bc = n % 16;
        int         tmp = int'(w);
        int         d;
        logic [7:0] p, q, b, v;
        p = 8'($urandom_range(10, 245));
        q = (p < 8'd128) ? p + 8'd8 : p - 8'd8;
        img[4*br][4*bc]     = p;
        img[4*br][4*bc + 1] = two ? q : p;
        for (int k = 2; k < 16; k++) begin
            d   = tmp % 3;
            tmp = tmp / 3;
            b   = (two && (k % 2 == 1)) ? q : p;
            v   = (d == 1) ? b + 8'd1 : (d == 2) ? b - 8'd1 : b;
            img[4*br + k/4][4*bc + k%4] = v;
        end
    endtask

    initial begin
        bit ok;
        int cyc, nw, seen;

        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++) img[r][c] = 8'h40;

        #2;
        check("rst_row", 64'(row), 64'd0);
        check("rst_col", 64'(col), 64'd0);
        check("rst_valid", 64'(word_valid), 64'd0);
        check("rst_data", 64'(word_data), 64'd0);
        check("rst_index", 64'(word_index), 64'd0);
        check("rst_string", 64'(decoded_string != '0), 64'd0);
        check("rst_done", 64'(decode_done), 64'd0);
        check("rst_err", 64'(fmt_error), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        blk0_fill(8'h50);
        run_blk0("uniform", 16'h0000, 1'b0);
        img[0][2] = 8'h51;
        run_blk0("one_up", 16'h0001, 1'b0);
        img[0][2] = 8'h4F;
        img[0][3] = 8'h51;
        run_blk0("two_dig", 16'h0005, 1'b0);

        blk0_fill(8'h80);
        img[0][3] = 8'h7F; img[1][2] = 8'h7F; img[1][3] = 8'h7F;
        img[2][0] = 8'h7F; img[2][1] = 8'h7F; img[3][0] = 8'h81;
        run_blk0("max_word", 16'hFFFF, 1'b0);

        blk0_fill(8'h20);
        img[1][1] = 8'h90; img[0][1] = 8'h21; img[1][2] = 8'h8F;
        run_blk0("two_level", 16'h00A3, 1'b0);
        img[2][0] = 8'h93;
        run_blk0("illegal_px", 16'h00A3, 1'b1);

        // Full image: block 0 has all digits = 2, i.e. 3^14-1 = 0x48FB78 overflows to 0xFB78.
        for (int n = 1; n < 256; n++) begin
            exp_words[n] = 16'($urandom_range(0, 65535));
            encode_block(n, exp_words[n], (n % 2) == 1);
        end
        blk0_fill(8'h4F);
        img[0][0] = 8'h50;
        img[0][1] = 8'h50;
        exp_words[0] = 16'hFB78;

        pulse_start();
        cyc = 0;
        nw  = 0;
        while (!decode_done && cyc < 9000) begin
            tick();
            cyc++;
            start = (cyc == 100);
            if (word_valid) begin
                check($sformatf("full_idx%0d", nw), 64'(word_index), 64'(nw));
                check($sformatf("full_dat%0d", nw), 64'(word_data), 64'(exp_words[nw % 256]));
                if (nw == 0) check("overflow_err", 64'(fmt_error), 64'd1);
                nw++;
            end
        end
        start = 1'b0;
        check("done_seen", 64'(decode_done), 64'd1);
        check("done_cycle", 64'(cyc), 64'd8448);
        check("word_count", 64'(nw), 64'd256);
        check("sticky_err", 64'(fmt_error), 64'd1);
        for (int n = 0; n < 256; n++)
            check($sformatf("string%0d", n), 64'(decoded_string[16*n +: 16]), 64'(exp_words[n]));

        // Restart from DONE with a legal block 0, then reset in the middle of block 3.
        exp_words[0] = 16'h1234;
        encode_block(0, exp_words[0], 1'b0);
        pulse_start();
        check("restart_done_clr", 64'(decode_done), 64'd0);
        check("restart_err_clr", 64'(fmt_error), 64'd0);
        check("restart_str_clr", 64'(decoded_string != '0), 64'd0);
        cyc = 0;
        while (cyc < 109) begin
            tick();
            cyc++;
            if (cyc == 86) begin
                check("hold_row", 64'(row), 64'd3);
                check("hold_col", 64'(col), 64'd11);
            end
            if (cyc == 104) begin
                check("read_row", 64'(row), 64'd1);
                check("read_col", 64'(col), 64'd13);
            end
        end
        check("blk3_str2", 64'(decoded_string[32 +: 16]), 64'(exp_words[2]));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_row", 64'(row), 64'd0);
        check("mid_rst_col", 64'(col), 64'd0);
        check("mid_rst_data", 64'(word_data), 64'd0);
        check("mid_rst_index", 64'(word_index), 64'd0);
        check("mid_rst_string", 64'(decoded_string != '0), 64'd0);
        check("mid_rst_err", 64'(fmt_error), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (word_valid) seen++;
        end
        check("no_word_after_rst", 64'(seen), 64'd0);

        pulse_start();
        wait_word(ok);
        check("rerun_valid", 64'(ok), 64'd1);
        if (ok) begin
            check("rerun_index", 64'(word_index), 64'd0);
            check("rerun_data", 64'(word_data), 64'(exp_words[0]));
            check("rerun_err", 64'(fmt_error), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
